conv_mac_engine: RTL and testbench

//  Parametrised, time-multiplexed KxK convolution engine for the CNN datapath: NUM_CH output channels.

---
 rtl/conv_pkg.sv | 20 ++
 rtl/conv_mac_lane.sv | 61 ++++++
 rtl/conv_mac_engine.sv | 137 +++++++++++++
 tb/tb_conv_mac_engine.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and width helpers for the KxK convolution MAC engine.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    OUT
  } state_e;

  // Full-precision accumulator width: product width plus growth for K*K terms.
  function automatic int acc_width(input int d, input int w, input int k);
    return d + w + $clog2(k * k);
  endfunction

  // Index width that stays at least one bit for single-entry ranges.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// One output channel: weight RAM column, sign-extended multiplier and accumulator.
module conv_mac_lane
  import conv_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int WEIGHT_W = 32,
  parameter int TAPS     = 25,
  parameter int ACC_W    = 69
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          mac_en,
  input  logic                          we,
  input  logic [idx_width(TAPS)-1:0]    wr_tap,
  input  logic signed [WEIGHT_W-1:0]    wr_data,
  input  logic [idx_width(TAPS)-1:0]    rd_tap,
  input  logic signed [DATA_W-1:0]      pixel,
  output logic [ACC_W-1:0]              acc
);

  logic signed [WEIGHT_W-1:0] w_q [TAPS];
  logic signed [WEIGHT_W-1:0] w_d [TAPS];
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [ACC_W-1:0]    px_ext, wt_ext, prod;

  always_comb begin
    w_d = w_q;
    if (we) begin
      w_d[wr_tap] = wr_data;
    end
  end

  // Operands widened to ACC_W first so the product and sum are exact.
  always_comb begin
    px_ext = ACC_W'(pixel);
    wt_ext = ACC_W'(w_q[rd_tap]);
    prod   = px_ext * wt_ext;
    acc_d  = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (mac_en) begin
      acc_d = acc_q + prod;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      for (int unsigned t = 0; t < TAPS; t++) begin
        w_q[t] <= '0;
      end
    end else begin
      acc_q <= acc_d;
      w_q   <= w_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/conv_mac_engine.sv
// Time-multiplexed KxK convolution engine: one tap per cycle across NUM_CH lanes.
module conv_mac_engine
  import conv_pkg::*;
#(
  parameter int K        = 5,
  parameter int NUM_CH   = 8,
  parameter int DATA_W   = 32,
  parameter int WEIGHT_W = 32
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          wgt_we,
  input  logic [idx_width(NUM_CH)-1:0]                  wgt_ch,
  input  logic [idx_width(K*K)-1:0]                     wgt_tap,
  input  logic [WEIGHT_W-1:0]                           wgt_data,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [K*K*DATA_W-1:0]                         in_window,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [NUM_CH*acc_width(DATA_W,WEIGHT_W,K)-1:0] out_data,
  output logic                                          busy,
  output logic                                          wgt_drop
);

  localparam int TAPS  = K * K;
  localparam int ACC_W = acc_width(DATA_W, WEIGHT_W, K);
  localparam int TAP_W = idx_width(TAPS);

  state_e                     state_q, state_d;
  logic [TAP_W-1:0]           tap_q, tap_d;
  logic [TAPS*DATA_W-1:0]     win_q, win_d;
  logic                       out_valid_q, out_valid_d;
  logic [NUM_CH*ACC_W-1:0]    out_data_q, out_data_d;
  logic                       wgt_drop_q, wgt_drop_d;

  logic                       accept, last_tap, mac_en, wgt_ok;
  logic [NUM_CH-1:0]          lane_we;
  logic [NUM_CH*ACC_W-1:0]    lane_acc;
  logic signed [DATA_W-1:0]   pixel;

  assign accept   = in_valid && in_ready;
  assign last_tap = (tap_q == TAP_W'(TAPS - 1));
  assign mac_en   = (state_q == ACC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ACC;
      ACC:     if (last_tap) state_d = OUT;
      OUT:     if (out_valid_q && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == IDLE) && !rst;
    busy     = (state_q == ACC) || (state_q == OUT);
  end

  // First OUT cycle captures the finished sums; out_valid follows one edge later.
  always_comb begin
    tap_d       = tap_q;
    win_d       = win_q;
    out_data_d  = out_data_q;
    out_valid_d = (state_q == OUT) && !(out_valid_q && out_ready);
    if (accept) begin
      tap_d = '0;
      win_d = in_window;
    end else if ((state_q == ACC) && !last_tap) begin
      tap_d = tap_q + TAP_W'(1);
    end
    if ((state_q == OUT) && !out_valid_q) begin
      out_data_d = lane_acc;
    end
    pixel = win_q[int'(tap_q)*DATA_W +: DATA_W];
  end

  // Writes only land between windows so a window never sees mixed weights.
  always_comb begin
    wgt_ok = wgt_we && (state_q == IDLE) && !accept &&
             (int'(wgt_ch) < NUM_CH) && (int'(wgt_tap) < TAPS);
    wgt_drop_d = wgt_we && !wgt_ok;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      lane_we[c] = wgt_ok && (int'(wgt_ch) == int'(c));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tap_q       <= '0;
      win_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      wgt_drop_q  <= 1'b0;
    end else begin
      tap_q       <= tap_d;
      win_q       <= win_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      wgt_drop_q  <= wgt_drop_d;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    conv_mac_lane #(
      .DATA_W   (DATA_W),
      .WEIGHT_W (WEIGHT_W),
      .TAPS     (TAPS),
      .ACC_W    (ACC_W)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .clr     (accept),
      .mac_en  (mac_en),
      .we      (lane_we[c]),
      .wr_tap  (wgt_tap),
      .wr_data (wgt_data),
      .rd_tap  (tap_q),
      .pixel   (pixel),
      .acc     (lane_acc[c*ACC_W +: ACC_W])
    );
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign wgt_drop  = wgt_drop_q;

endmodule

// File: tb/tb_conv_mac_engine.sv
// Scoreboard bench for conv_mac_engine at K=3, NUM_CH=2, 8-bit data and weights.
module tb_conv_mac_engine;

  localparam int K      = 3;
  localparam int NUM_CH = 2;
  localparam int DW     = 8;
  localparam int WW     = 8;
  localparam int TAPS   = K * K;
  localparam int ACC_W  = 20;
  localparam int OW     = NUM_CH * ACC_W;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 wgt_we;
  logic [0:0]           wgt_ch;
  logic [3:0]           wgt_tap;
  logic [WW-1:0]        wgt_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [TAPS*DW-1:0]   in_window;
  logic                 out_valid;
  logic                 out_ready;
  logic [OW-1:0]        out_data;
  logic                 busy;
  logic                 wgt_drop;

  conv_mac_engine #(
    .K        (K),
    .NUM_CH   (NUM_CH),
    .DATA_W   (DW),
    .WEIGHT_W (WW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wgt_we    (wgt_we),
    .wgt_ch    (wgt_ch),
    .wgt_tap   (wgt_tap),
    .wgt_data  (wgt_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_window (in_window),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .wgt_drop  (wgt_drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [OW-1:0] data;
    int            acyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic ov_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [OW-1:0] pack2(input int ch0, input int ch1);
    return {20'(ch1), 20'(ch0)};
  endfunction

  function automatic logic [TAPS*DW-1:0] win_seq();
    logic [TAPS*DW-1:0] w;
    for (int i = 0; i < TAPS; i++) w[i*DW +: DW] = 8'(i + 1);
    return w;
  endfunction

  function automatic logic [TAPS*DW-1:0] win_all(input int v);
    logic [TAPS*DW-1:0] w;
    for (int i = 0; i < TAPS; i++) w[i*DW +: DW] = 8'(v);
    return w;
  endfunction

  // Monitor: latency on each rising out_valid, data on each output handshake.
  always @(negedge clk) begin
    if (out_valid && !ov_prev) begin
      if (sb.size() == 0) check("unexpected_out", 64'(out_valid), 64'd0);
      else check("latency", 64'(cyc - sb[0].acyc - 1), 64'(TAPS + 1));
    end
    if (out_valid && out_ready && sb.size() != 0) begin
      check("out_data", 64'(out_data), 64'(sb[0].data));
      void'(sb.pop_front());
    end
    ov_prev = out_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input int tap, input int data);
    wgt_ch   = 1'(ch);
    wgt_tap  = 4'(tap);
    wgt_data = 8'(data);
    wgt_we   = 1'b1;
    tick();
    wgt_we   = 1'b0;
  endtask

  task automatic accept(input logic [TAPS*DW-1:0] w, output int acyc);
    bit got = 0;
    in_window = w;
    in_valid  = 1'b1;
    acyc      = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acyc = cyc;
        got  = 1;
        break;
      end
    end
    if (!got) check("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  a;
    bit  seen;
    rst       = 1'b1;
    wgt_we    = 1'b0;
    wgt_ch    = '0;
    wgt_tap   = '0;
    wgt_data  = '0;
    in_valid  = 1'b0;
    in_window = '0;
    out_ready = 1'b1;
    repeat (3) tick();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_wgt_drop", 64'(wgt_drop), 64'd0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", 64'(in_ready), 64'd1);

    // Basic sums and latency
    for (int t = 0; t < TAPS; t++) wr(0, t, 1);
    wr(1, 4, -1);
    accept(win_seq(), a);
    sb.push_back('{pack2(45, -5), a});
    drain();

    // Extreme negative operands
    for (int t = 0; t < TAPS; t++) wr(0, t, -128);
    accept(win_all(-128), a);
    sb.push_back('{pack2(147456, 128), a});
    drain();

    // Backpressure stall
    out_ready = 1'b0;
    accept(win_all(1), a);
    sb.push_back('{pack2(-1152, -1), a});
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check("stall_valid_timeout", 64'(out_valid), 64'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_data", 64'(out_data), 64'(pack2(-1152, -1)));
      check("stall_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    accept(win_all(2), a);
    sb.push_back('{pack2(-2304, -2), a});
    drain();

    // Weight write during ACC is dropped
    accept(win_all(1), a);
    wr(0, 0, 7);
    check("drop_in_acc", 64'(wgt_drop), 64'd1);
    sb.push_back('{pack2(-1152, -1), a});
    drain();
    wr(0, 0, 7);
    check("no_drop_idle", 64'(wgt_drop), 64'd0);
    wr(0, 9, 55);
    check("drop_tap_range", 64'(wgt_drop), 64'd1);

    // Same-cycle write and acceptance: acceptance wins
    in_window = win_all(1);
    in_valid  = 1'b1;
    wgt_ch    = 1'b1;
    wgt_tap   = 4'd4;
    wgt_data  = 8'd100;
    wgt_we    = 1'b1;
    @(negedge clk);
    a = cyc;
    check("same_cycle_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wgt_we   = 1'b0;
    check("drop_same_cycle", 64'(wgt_drop), 64'd1);
    check("busy_after_accept", 64'(busy), 64'd1);
    sb.push_back('{pack2(-1017, -1), a});
    drain();

    // Reset mid-window abandons it and clears the weights
    accept(win_seq(), a);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_data", 64'(out_data), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    accept(win_seq(), a);
    sb.push_back('{pack2(0, 0), a});
    drain();

    repeat (5) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
